// File: rtl/matrix_keyboard_emulator_pkg.sv
// Shared definitions for the matrix keyboard emulator: FSM states,
// key-code field positions and the idle column pattern.
package matrix_keyboard_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRESS_B,
        ST_HOLD,
        ST_REL_B,
        ST_GAP
    } kbd_state_e;

    localparam int unsigned KEY_W   = 4;
    localparam int unsigned ROW_MSB = 3;
    localparam int unsigned ROW_LSB = 2;
    localparam int unsigned COL_MSB = 1;
    localparam int unsigned COL_LSB = 0;

    localparam logic [3:0] COL_IDLE = 4'hF;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/matrix_keyboard_emulator_if.sv
// Key-press request handshake and status between the injector and the keypad model.
interface matrix_keyboard_emulator_if;
    import matrix_keyboard_pkg::*;

    logic             req_valid;
    logic [KEY_W-1:0] req_code;
    logic             req_ready;
    logic             busy;
    logic             done;

    modport master (
        output req_valid, req_code,
        input  req_ready, busy, done
    );

    modport slave (
        input  req_valid, req_code,
        output req_ready, busy, done
    );

endinterface

// File: rtl/matrix_keyboard_emulator_phase_timer.sv
// Loadable down-counter; holds at zero until reloaded.
module kbd_phase_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= value;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/matrix_keyboard_emulator.sv
// Keypad-side model of a 4x4 matrix keyboard: presses one key per request with
// contact bounce, hold and release gap, answering the scanner's row strobes on col.
module matrix_keyboard_emulator
    import matrix_keyboard_pkg::*;
#(
    parameter int unsigned PRESS_CYC   = 2_000_000,
    parameter int unsigned RELEASE_CYC = 2_000_000,
    parameter int unsigned BOUNCE_CYC  = 50_000,
    parameter int unsigned BOUNCE_N    = 4
) (
    input  logic                        clk_100M,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic [3:0]                  row,
    output logic [3:0]                  col,
    matrix_keyboard_emulator_if.slave   bus
);

    localparam int unsigned MAX_CYC = max3(PRESS_CYC, RELEASE_CYC, BOUNCE_CYC);
    localparam int unsigned CW      = $clog2(MAX_CYC + 1);
    localparam int unsigned PW      = (BOUNCE_N > 0) ? $clog2(BOUNCE_N + 1) : 1;

    // Counter runs value..0, so every phase lasts exactly its configured clocks.
    localparam logic [CW-1:0] PRESS_LD  = CW'(PRESS_CYC - 1);
    localparam logic [CW-1:0] REL_LD    = CW'(RELEASE_CYC - 1);
    localparam logic [CW-1:0] BOUNCE_LD = CW'(BOUNCE_CYC - 1);
    localparam logic [PW-1:0] LAST_PH   = PW'((BOUNCE_N > 0) ? BOUNCE_N - 1 : 0);

    kbd_state_e       state, state_n;
    logic [PW-1:0]    phase, phase_n;
    logic [KEY_W-1:0] code_q;
    logic             load;
    logic [CW-1:0]    load_val;
    logic             zero;
    logic             contact;
    logic             accept;
    logic             gap_end;
    logic             ready_q, busy_q, done_q;
    logic [3:0]       col_n;

    kbd_phase_timer #(.W(CW)) u_timer (
        .clk   (clk_100M),
        .rst_n (rst_n),
        .load  (load),
        .value (load_val),
        .zero  (zero)
    );

    assign accept  = bus.req_valid && ready_q && en && (state == ST_IDLE);
    assign gap_end = en && (state == ST_GAP) && zero;

    always_comb begin
        state_n  = state;
        phase_n  = phase;
        load     = 1'b0;
        load_val = PRESS_LD;
        contact  = 1'b0;
        if (!en) begin
            state_n = ST_IDLE;
            phase_n = '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        load    = 1'b1;
                        phase_n = '0;
                        if (BOUNCE_N == 0) begin
                            state_n  = ST_HOLD;
                            load_val = PRESS_LD;
                        end else begin
                            state_n  = ST_PRESS_B;
                            load_val = BOUNCE_LD;
                        end
                    end
                end
                ST_PRESS_B: begin
                    contact = ~phase[0];
                    if (zero) begin
                        load = 1'b1;
                        if (phase == LAST_PH) begin
                            state_n  = ST_HOLD;
                            phase_n  = '0;
                            load_val = PRESS_LD;
                        end else begin
                            phase_n  = phase + 1'b1;
                            load_val = BOUNCE_LD;
                        end
                    end
                end
                ST_HOLD: begin
                    contact = 1'b1;
                    if (zero) begin
                        load    = 1'b1;
                        phase_n = '0;
                        if (BOUNCE_N == 0) begin
                            state_n  = ST_GAP;
                            load_val = REL_LD;
                        end else begin
                            state_n  = ST_REL_B;
                            load_val = BOUNCE_LD;
                        end
                    end
                end
                ST_REL_B: begin
                    contact = phase[0];
                    if (zero) begin
                        load = 1'b1;
                        if (phase == LAST_PH) begin
                            state_n  = ST_GAP;
                            phase_n  = '0;
                            load_val = REL_LD;
                        end else begin
                            phase_n  = phase + 1'b1;
                            load_val = BOUNCE_LD;
                        end
                    end
                end
                ST_GAP: begin
                    if (zero) state_n = ST_IDLE;
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    // Only the pressed key's row strobe matters; other low rows leave col idle.
    always_comb begin
        col_n = COL_IDLE;
        if (contact && !row[code_q[ROW_MSB:ROW_LSB]])
            col_n[code_q[COL_MSB:COL_LSB]] = 1'b0;
    end

    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            phase   <= '0;
            code_q  <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            col     <= COL_IDLE;
        end else begin
            state   <= state_n;
            phase   <= phase_n;
            if (accept) code_q <= bus.req_code;
            ready_q <= en && (state == ST_IDLE) && (state_n == ST_IDLE);
            busy_q  <= en && ((state_n != ST_IDLE) || gap_end);
            done_q  <= gap_end;
            col     <= col_n;
        end
    end

    assign bus.req_ready = ready_q && en;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_matrix_keyboard_emulator.sv
// Directed bench for matrix_keyboard_emulator: one no-bounce and one bounce instance.
module tb_matrix_keyboard_emulator;

    logic       clk_100M = 1'b0;
    logic       rst_n;
    logic       en_a, en_b;
    logic [3:0] row_a, row_b, col_a, col_b;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk_100M = ~clk_100M;

    matrix_keyboard_emulator_if bus_a ();
    matrix_keyboard_emulator_if bus_b ();

    matrix_keyboard_emulator #(
        .PRESS_CYC   (20),
        .RELEASE_CYC (10),
        .BOUNCE_CYC  (1),
        .BOUNCE_N    (0)
    ) dut_a (
        .clk_100M (clk_100M),
        .rst_n    (rst_n),
        .en       (en_a),
        .row      (row_a),
        .col      (col_a),
        .bus      (bus_a)
    );

    matrix_keyboard_emulator #(
        .PRESS_CYC   (6),
        .RELEASE_CYC (5),
        .BOUNCE_CYC  (3),
        .BOUNCE_N    (4)
    ) dut_b (
        .clk_100M (clk_100M),
        .rst_n    (rst_n),
        .en       (en_b),
        .row      (row_b),
        .col      (col_b),
        .bus      (bus_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_100M);
        #1;
    endtask

    // Contact state of dut_b during cycle k after accept (4 bounce phases of 3 clocks).
    function automatic logic closed_b(input int k);
        return (k >= 1  && k <= 3)  || (k >= 7  && k <= 9)  || (k >= 13 && k <= 18) ||
               (k >= 22 && k <= 24) || (k >= 28 && k <= 30);
    endfunction

    initial begin
        logic [3:0] exp_col;

        rst_n = 1'b0;
        en_a  = 1'b1;
        en_b  = 1'b1;
        row_a = 4'b1011;
        row_b = 4'b1110;
        bus_a.req_valid = 1'b0;
        bus_a.req_code  = 4'h0;
        bus_b.req_valid = 1'b0;
        bus_b.req_code  = 4'h0;

        tick();
        tick();
        check_eq("rst_col_a",   col_a,           4'hF);
        check_eq("rst_col_b",   col_b,           4'hF);
        check_eq("rst_busy_a",  bus_a.busy,      1'b0);
        check_eq("rst_done_a",  bus_a.done,      1'b0);
        check_eq("rst_ready_a", bus_a.req_ready, 1'b0);
        check_eq("rst_ready_b", bus_b.req_ready, 1'b0);
        rst_n = 1'b1;
        tick();
        check_eq("post_rst_ready_a", bus_a.req_ready, 1'b1);
        check_eq("post_rst_ready_b", bus_b.req_ready, 1'b1);
        check_eq("post_rst_col_a",   col_a,           4'hF);
        check_eq("post_rst_busy_a",  bus_a.busy,      1'b0);

        // Single press of key 9 (row 2, col 1), no bounce; accept cycle is k=0.
        bus_a.req_valid = 1'b1;
        bus_a.req_code  = 4'h9;
        for (int k = 1; k <= 32; k++) begin
            tick();
            if (k == 1) begin
                bus_a.req_valid = 1'b0;
                bus_a.req_code  = 4'h0;
            end
            exp_col = (k >= 2 && k <= 21 && k != 9 && k != 10) ? 4'b1101 : 4'hF;
            check_eq($sformatf("a_col k=%0d", k),   col_a,           exp_col);
            check_eq($sformatf("a_done k=%0d", k),  bus_a.done,      k == 31);
            check_eq($sformatf("a_busy k=%0d", k),  bus_a.busy,      k <= 31);
            check_eq($sformatf("a_ready k=%0d", k), bus_a.req_ready, k == 32);
            row_a = (k == 8 || k == 9) ? 4'b1101 : (k == 12) ? 4'b0000 : 4'b1011;
        end

        // Back-to-back: valid held high, code 5 then code 12, all rows strobed.
        row_a = 4'b0000;
        bus_a.req_valid = 1'b1;
        bus_a.req_code  = 4'h5;
        for (int k = 1; k <= 64; k++) begin
            tick();
            if (k == 1)  bus_a.req_code  = 4'hC;
            if (k == 33) bus_a.req_valid = 1'b0;
            exp_col = (k >= 2 && k <= 21)  ? 4'b1101 :
                      (k >= 34 && k <= 53) ? 4'b1110 : 4'hF;
            check_eq($sformatf("b2b_col k=%0d", k),   col_a,           exp_col);
            check_eq($sformatf("b2b_done k=%0d", k),  bus_a.done,      k == 31 || k == 63);
            check_eq($sformatf("b2b_busy k=%0d", k),  bus_a.busy,      k != 32 && k != 64);
            check_eq($sformatf("b2b_ready k=%0d", k), bus_a.req_ready, k == 32 || k == 64);
        end

        // Bounce shape on key 2 (row 0, col 2).
        check_eq("b_ready_idle", bus_b.req_ready, 1'b1);
        bus_b.req_valid = 1'b1;
        bus_b.req_code  = 4'h2;
        for (int k = 1; k <= 37; k++) begin
            tick();
            if (k == 1) bus_b.req_valid = 1'b0;
            exp_col = closed_b(k - 1) ? 4'b1011 : 4'hF;
            check_eq($sformatf("bnc_col k=%0d", k),  col_b,      exp_col);
            check_eq($sformatf("bnc_done k=%0d", k), bus_b.done, k == 36);
            check_eq($sformatf("bnc_busy k=%0d", k), bus_b.busy, k <= 36);
        end
        check_eq("bnc_ready_end", bus_b.req_ready, 1'b1);

        // Abort: en dropped during HOLD, raised again later.
        bus_b.req_valid = 1'b1;
        bus_b.req_code  = 4'h2;
        for (int k = 1; k <= 45; k++) begin
            tick();
            if (k == 1) bus_b.req_valid = 1'b0;
            if (k <= 14)
                exp_col = closed_b(k - 1) ? 4'b1011 : 4'hF;
            else
                exp_col = 4'hF;
            check_eq($sformatf("abt_col k=%0d", k),  col_b,      exp_col);
            check_eq($sformatf("abt_done k=%0d", k), bus_b.done, 1'b0);
            check_eq($sformatf("abt_busy k=%0d", k), bus_b.busy, k <= 14);
            if (k >= 15)
                check_eq($sformatf("abt_ready k=%0d", k), bus_b.req_ready, k >= 21);
            if (k == 14) en_b = 1'b0;
            if (k == 20) en_b = 1'b1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
